// File: rtl/bp_pht_lookup.sv
// Pattern history table of 2-bit saturating counters: 1-cycle lookup port, single-cycle update port.
// Optional gshare indexing (global history XOR PC index) enabled by defining PHT_GSHARE_EN.
module bp_pht_lookup #(
    parameter int unsigned  ENTRIES = 32,
    parameter logic [1:0]   RST_CTR = 2'b01,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_valid,
    input  logic [31:0]      lookup_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [1:0]       pred_ctr,
`ifdef PHT_GSHARE_EN
    output logic [IDX_W-1:0] pred_ghr,
    input  logic [IDX_W-1:0] upd_ghr,
`endif
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken
);

    logic [ENTRIES-1:0][1:0] ctr_q, ctr_d;
    logic                    pred_valid_q, pred_valid_d;
    logic [1:0]              pred_ctr_q, pred_ctr_d;
    logic [IDX_W-1:0]        lkp_idx, upd_idx;
    logic [1:0]              upd_old, upd_new, lkp_val;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                              upd_pc[31:IDX_W+2], upd_pc[1:0]};

`ifdef PHT_GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;
    logic [IDX_W-1:0] pred_ghr_q, pred_ghr_d;

    // Lookup hashes with the pre-shift history; update uses the snapshot carried down the pipe.
    assign lkp_idx = lookup_pc[IDX_W+1:2] ^ ghr_q;
    assign upd_idx = upd_pc[IDX_W+1:2] ^ upd_ghr;

    always_comb begin
        ghr_d      = ghr_q;
        pred_ghr_d = pred_ghr_q;
        if (upd_valid) begin
            ghr_d = (ghr_q << 1) | IDX_W'(upd_taken);
        end
        if (lookup_valid) begin
            pred_ghr_d = ghr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q      <= '0;
            pred_ghr_q <= '0;
        end else begin
            ghr_q      <= ghr_d;
            pred_ghr_q <= pred_ghr_d;
        end
    end

    assign pred_ghr = pred_ghr_q;
`else
    assign lkp_idx = lookup_pc[IDX_W+1:2];
    assign upd_idx = upd_pc[IDX_W+1:2];
`endif

    always_comb begin
        upd_old = ctr_q[upd_idx];
        if (upd_taken) begin
            upd_new = (upd_old == 2'b11) ? 2'b11 : upd_old + 2'b01;
        end else begin
            upd_new = (upd_old == 2'b00) ? 2'b00 : upd_old - 2'b01;
        end

        ctr_d = ctr_q;
        if (upd_valid) begin
            ctr_d[upd_idx] = upd_new;
        end

        // Write-first: a same-edge update to the looked-up entry is forwarded.
        lkp_val = (upd_valid && (upd_idx == lkp_idx)) ? upd_new : ctr_q[lkp_idx];

        pred_valid_d = lookup_valid;
        pred_ctr_d   = pred_ctr_q;
        if (lookup_valid) begin
            pred_ctr_d = lkp_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q        <= {ENTRIES{RST_CTR}};
            pred_valid_q <= 1'b0;
            pred_ctr_q   <= 2'b00;
        end else begin
            ctr_q        <= ctr_d;
            pred_valid_q <= pred_valid_d;
            pred_ctr_q   <= pred_ctr_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_ctr   = pred_ctr_q;
    assign pred_taken = pred_ctr_q[1];

endmodule

// File: tb/tb_bp_pht_lookup.sv
// Self-checking bench for bp_pht_lookup: directed scenarios plus randomized traffic against
// an array-of-integers counter model. Define PHT_GSHARE_EN to exercise gshare indexing.
module tb_bp_pht_lookup;

    localparam int ENTRIES = 32;
    localparam int IDX_W   = 5;
    localparam int MASK    = ENTRIES - 1;

    logic             clk;
    logic             rst_n;
    logic             lookup_valid;
    logic [31:0]      lookup_pc;
    logic             pred_valid;
    logic             pred_taken;
    logic [1:0]       pred_ctr;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic [IDX_W-1:0] pred_ghr;
    logic [IDX_W-1:0] upd_ghr;

    int n_cmp;
    int n_err;

    // Reference model: plain integers, saturating arithmetic.
    int model_ctr [ENTRIES];
    int model_ghr;

    bp_pht_lookup #(
        .ENTRIES (ENTRIES),
        .RST_CTR (2'b01)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .pred_ctr     (pred_ctr),
`ifdef PHT_GSHARE_EN
        .pred_ghr     (pred_ghr),
        .upd_ghr      (upd_ghr),
`endif
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken)
    );

`ifndef PHT_GSHARE_EN
    assign pred_ghr = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input logic [31:0] lpc, input logic uv,
                         input logic [31:0] upc, input logic ut);
        lookup_valid = lv;
        lookup_pc    = lpc;
        upd_valid    = uv;
        upd_pc       = upc;
        upd_taken    = ut;
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) model_ctr[i] = 1;
        model_ghr = 0;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        upd_ghr = '0;
        rst_n = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        upd_ghr = '0;
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (pred_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pred_valid: got %b want 0", pred_valid);
        end
        n_cmp++;
        if (pred_ctr !== 2'b00 || pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pred_ctr: got ctr=%b taken=%b want 00/0", pred_ctr, pred_taken);
        end
        n_cmp++;
        if (pred_ghr !== '0) begin
            n_err++;
            $display("FAIL reset_pred_ghr: got %b want 0", pred_ghr);
        end
        #2 rst_n = 1'b1;
        model_reset();
        tick();
        drive(1'b1, 32'h0000_0040, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_cmp++;
        if (pred_valid !== 1'b1 || pred_ctr !== 2'b01 || pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL first_lookup: got v=%b ctr=%b t=%b want 1/01/0",
                     pred_valid, pred_ctr, pred_taken);
        end
        tick();
        n_cmp++;
        if (pred_valid !== 1'b0 || pred_ctr !== 2'b01) begin
            n_err++;
            $display("FAIL lookup_one_shot_hold: got v=%b ctr=%b want 0/01", pred_valid, pred_ctr);
        end
    endtask

`ifndef PHT_GSHARE_EN
    task automatic test_saturation();
        logic [1:0] want_up [4];
        want_up[0] = 2'b10;
        want_up[1] = 2'b11;
        want_up[2] = 2'b11;
        want_up[3] = 2'b11;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h10, 1'b1);
            tick();
            drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
            tick();
            n_cmp++;
            if (pred_valid !== 1'b1 || pred_ctr !== want_up[i]) begin
                n_err++;
                $display("FAIL sat_up_%0d: got v=%b ctr=%b want 1/%b",
                         i, pred_valid, pred_ctr, want_up[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
            tick();
        end
        drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_cmp++;
        if (pred_ctr !== 2'b00 || pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL sat_down: got ctr=%b t=%b want 00/0", pred_ctr, pred_taken);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        drive(1'b1, 32'h10, 1'b1, 32'h10, 1'b1);
        tick();
        n_cmp++;
        if (pred_valid !== 1'b1 || pred_ctr !== 2'b10 || pred_taken !== 1'b1) begin
            n_err++;
            $display("FAIL fwd_same_idx: got v=%b ctr=%b t=%b want 1/10/1",
                     pred_valid, pred_ctr, pred_taken);
        end
        drive(1'b1, 32'h14, 1'b1, 32'h10, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_cmp++;
        if (pred_ctr !== 2'b01) begin
            n_err++;
            $display("FAIL fwd_diff_idx: got ctr=%b want 01", pred_ctr);
        end
    endtask

    task automatic test_aliasing();
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 32'h04, 1'b1);
        tick();
        tick();
        drive(1'b1, 32'h84, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_cmp++;
        if (pred_ctr !== 2'b11 || pred_taken !== 1'b1) begin
            n_err++;
            $display("FAIL alias: got ctr=%b t=%b want 11/1", pred_ctr, pred_taken);
        end
    endtask
`else
    task automatic test_gshare();
        do_reset();
        upd_ghr = '0;
        drive(1'b0, 32'h0, 1'b1, 32'h44, 1'b1);
        tick();
        tick();
        drive(1'b1, 32'h0C, 1'b0, 32'h0, 1'b0);
        tick();
        n_cmp++;
        if (pred_ghr !== 5'b00011 || pred_ctr !== 2'b01) begin
            n_err++;
            $display("FAIL gshare_lookup: got ghr=%b ctr=%b want 00011/01", pred_ghr, pred_ctr);
        end
        upd_ghr = 5'b00011;
        drive(1'b0, 32'h0, 1'b1, 32'h0C, 1'b1);
        tick();
        upd_ghr = '0;
        // ghr is now 00111: pc idx 7 -> entry 0, idx 4 -> entry 3, idx 22 -> entry 17.
        drive(1'b1, 32'h1C, 1'b0, 32'h0, 1'b0);
        tick();
        n_cmp++;
        if (pred_ctr !== 2'b10 || pred_ghr !== 5'b00111) begin
            n_err++;
            $display("FAIL gshare_entry0: got ctr=%b ghr=%b want 10/00111", pred_ctr, pred_ghr);
        end
        drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        tick();
        n_cmp++;
        if (pred_ctr !== 2'b01) begin
            n_err++;
            $display("FAIL gshare_entry3: got ctr=%b want 01", pred_ctr);
        end
        drive(1'b1, 32'h58, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_cmp++;
        if (pred_ctr !== 2'b11) begin
            n_err++;
            $display("FAIL gshare_entry17: got ctr=%b want 11", pred_ctr);
        end
    endtask
`endif

    task automatic test_random();
        logic        lv, uv, ut;
        logic [31:0] lpc, upc;
        int          lidx, uidx, ughr, want_ctr, want_ghr;
        logic        want_valid;
        do_reset();
        want_ctr = 0;
        want_ghr = 0;
        for (int n = 0; n < 400; n++) begin
            lv  = ($urandom_range(0, 3) != 0);
            uv  = ($urandom_range(0, 2) != 0);
            ut  = $urandom_range(0, 1);
            lpc = ($urandom_range(0, 1) != 0) ? $urandom : {$urandom_range(0, 15), 2'b00};
            upc = ($urandom_range(0, 3) == 0) ? lpc : $urandom;
`ifdef PHT_GSHARE_EN
            ughr = ($urandom_range(0, 1) != 0) ? model_ghr : int'($urandom_range(0, MASK));
            lidx = ((lpc >> 2) & MASK) ^ model_ghr;
`else
            ughr = 0;
            lidx = (lpc >> 2) & MASK;
`endif
            uidx = ((upc >> 2) & MASK) ^ ughr;
            upd_ghr = IDX_W'(ughr);
            drive(lv, lpc, uv, upc, ut);
            if (uv) begin
                if (ut) model_ctr[uidx] = (model_ctr[uidx] == 3) ? 3 : model_ctr[uidx] + 1;
                else    model_ctr[uidx] = (model_ctr[uidx] == 0) ? 0 : model_ctr[uidx] - 1;
            end
            want_valid = lv;
            if (lv) begin
                want_ctr = model_ctr[lidx];
`ifdef PHT_GSHARE_EN
                want_ghr = model_ghr;
`endif
            end
            if (uv) model_ghr = ((model_ghr << 1) | int'(ut)) & MASK;
            tick();
            n_cmp++;
            if (pred_valid !== want_valid || pred_ctr !== 2'(want_ctr)
                || pred_taken !== (want_ctr >= 2) || pred_ghr !== IDX_W'(want_ghr)) begin
                n_err++;
                $display("FAIL rand_%0d: got v=%b ctr=%b t=%b ghr=%b want v=%b ctr=%0d ghr=%0d",
                         n, pred_valid, pred_ctr, pred_taken, pred_ghr,
                         want_valid, want_ctr, want_ghr);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        upd_ghr = '0;
    endtask

    task automatic test_async_reset();
        // Leave non-reset counter values behind so the post-reset sweep is meaningful.
        for (int i = 0; i < ENTRIES; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'(i << 2), (i % 2) == 0);
            tick();
        end
        drive(1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_cmp++;
        if (pred_valid !== 1'b1) begin
            n_err++;
            $display("FAIL async_pre: got v=%b want 1", pred_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pred_valid !== 1'b0 || pred_ctr !== 2'b00) begin
            n_err++;
            $display("FAIL async_discard: got v=%b ctr=%b want 0/00", pred_valid, pred_ctr);
        end
        #10 rst_n = 1'b1;
        model_reset();
        tick();
        for (int i = 0; i < ENTRIES; i++) begin
            drive(1'b1, 32'(i << 2), 1'b0, 32'h0, 1'b0);
            tick();
            n_cmp++;
            if (pred_valid !== 1'b1 || pred_ctr !== 2'b01) begin
                n_err++;
                $display("FAIL async_sweep_%0d: got v=%b ctr=%b want 1/01",
                         i, pred_valid, pred_ctr);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        test_reset();
`ifndef PHT_GSHARE_EN
        test_saturation();
        test_forwarding();
        test_aliasing();
`else
        test_gshare();
`endif
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bp_pht_lookup.md
Name: bp_pht_lookup

Overview:
- Pattern history table: an array of 2-bit saturating up/down counters for the branch predictor.
- Two ports:
  - Lookup side reads a counter and produces a taken/not-taken prediction for the fetch stage.
  - Update side reads, modifies and writes a counter when the execute stage resolves a branch.
- Sits between fetch (lookup) and execute (update).
- Provides the read/predict end of the counter protocol; a saturating counter is the write end.

Parameters:
- ENTRIES, 32, number of counters; power of two, 2 to 1024.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.
- RST_CTR, 2'b01, counter value loaded on reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  lookup request this cycle.
- lookup_pc  in  32  PC of the instruction being fetched.
- pred_valid  out  1  registered; high one cycle after an accepted lookup.
- pred_taken  out  1  registered; MSB of the counter used for the prediction.
- pred_ctr  out  2  registered; full counter value used for the prediction.
- upd_valid  in  1  resolved-branch update this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual branch outcome.

Behaviour:
- Counter encoding:
  - 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
  - Prediction is the MSB.
- Index (base): idx = pc[IDX_W+1:2]. PC bits [1:0] and bits above IDX_W+1 are ignored.
- Reset (async, rst_n=0):
  - All ENTRIES counters = RST_CTR.
  - pred_valid=0, pred_taken=0, pred_ctr=2'b00.
  - A reset asserted mid-operation discards any in-flight lookup result.
  - First lookup after reset release returns RST_CTR.
- Lookup latency = 1 cycle:
  - lookup_valid sampled at edge N; pred_* valid after edge N, i.e. during cycle N+1.
  - No stall and no backpressure: a new lookup is accepted every cycle.
  - pred_valid is held for exactly one cycle per lookup.
  - pred_taken and pred_ctr hold their last value when pred_valid=0.
- Update, single cycle, on the edge where upd_valid=1:
  - upd_taken=1: ctr = (ctr==11) ? 11 : ctr+1.
  - upd_taken=0: ctr = (ctr==00) ? 00 : ctr-1.
  - Saturation is mandatory; no wrap-around (11+1 stays 11, 00-1 stays 00).
- Simultaneous lookup and update, same index, same edge:
  - Lookup returns the post-update value (write-first forwarding).
  - Example: ctr=01, upd_taken=1, lookup same idx -> pred_ctr=10, pred_taken=1.
- Simultaneous lookup and update, different indices: independent; lookup returns the stored value.
- Aliasing: distinct PCs with equal idx share a counter. This is intended, not an error.
- Only one counter is written per cycle. At most one update per cycle is guaranteed by execute.

Optional Feature:
- Macro: PHT_GSHARE_EN.
- Defined (gshare indexing):
  - Block contains a global history register ghr[IDX_W-1:0], reset to 0.
  - Lookup index = lookup_pc[IDX_W+1:2] ^ ghr, using the current ghr.
  - Added output pred_ghr [IDX_W-1:0]: registered snapshot of the ghr used by the lookup, aligned with pred_valid.
  - Added input upd_ghr [IDX_W-1:0]: snapshot carried down the pipe; update index = upd_pc[IDX_W+1:2] ^ upd_ghr.
  - On upd_valid: ghr <= {ghr[IDX_W-2:0], upd_taken}.
  - When lookup and update hit the same edge, the lookup uses the pre-shift ghr.
  - Forwarding compares the final XORed indices.
- Undefined:
  - No ghr, no pred_ghr or upd_ghr ports.
  - Indexing is the base PC-bit index only.

Test Plan:
- Reset then lookup pc=0x0000_0040 -> next cycle pred_valid=1, pred_ctr=01, pred_taken=0; cycle after that, pred_valid=0.
- Saturation, pc=0x10: four updates with upd_taken=1 -> counter 01->10->11->11->11; lookup returns 11. Three updates with upd_taken=0 -> 10,01,00; a further not-taken update stays 00; lookup returns 00.
- Forwarding: ctr[idx 4]=01; same edge upd_valid=1, upd_pc=0x10, upd_taken=1, lookup_pc=0x10 -> pred_ctr=10, pred_taken=1.
- Aliasing, ENTRIES=32: update pc=0x04 taken twice; lookup pc=0x84 -> pred_ctr=11 (both map to idx 1).
- Async reset mid-stream: lookup at edge N, rst_n low before edge N+1 -> pred_valid=0 immediately; after release, all counters return 01.
- PHT_GSHARE_EN: updates taken,taken from reset -> ghr=00011. Lookup pc=0x0C -> idx=3^3=0, pred_ghr=00011. Update pc=0x0C with upd_ghr=00011 modifies entry 0 only.
